v_lsu_seq: RTL and testbench

V_LSU_SEQ -- requirements
Module: v_lsu_seq

---
 rtl/v_lsu_seq_if.sv | 36 +++
 rtl/v_lsu_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_v_lsu_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_lsu_seq_if.sv
// ---------------------------------------------------------------------------
// v_lsu_seq_if -- memory request/response bus used by the vector LSU.
//
// One request is outstanding at a time. The master holds req with stable
// addr/be/wdata until gnt. For a load, the answer arrives later on
// rvalid/rdata.
//
//   req    master -> slave  request valid
//   we     master -> slave  1 = store, 0 = load
//   addr   master -> slave  word-aligned byte address
//   be     master -> slave  byte enables
//   wdata  master -> slave  store data, already shifted into its byte lane(s)
//   gnt    slave -> master  request accepted this cycle
//   rvalid slave -> master  load data valid this cycle
//   rdata  slave -> master  load data word
// ---------------------------------------------------------------------------
interface v_lsu_seq_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/v_lsu_seq.sv
// ---------------------------------------------------------------------------
// v_lsu_seq -- sequential vector load/store unit.
//
// The unit accepts one vector memory command at a time and walks its
// elements one by one. There is one bus request per element. Unit-stride
// and strided loads and stores are supported, with element widths of
// 8, 16 or 32 bits.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   start            command valid (sampled only while ready)
//   op[3:0]          1..3 VLE8/16/32, 4..6 VLSE8/16/32,
//                    7..9 VSE8/16/32, 10..12 VSSE8/16/32
//   base[31:0]       byte base address
//   stride[31:0]     byte stride (signed, strided ops only)
//   vl               element count
//   ready / busy     idle / command in flight
//   done / err       one-cycle end-of-command pulse / error flag with it
//   mem              memory bus (master side)
//   elem_idx         current element; addresses the VRF read port
//   vrf_rdata        store element from the VRF, LSB-aligned
//   vrf_we/widx/wdata  load element write-back to the VRF
// ---------------------------------------------------------------------------
module v_lsu_seq #(
  parameter  int MAX_VL = 32,
  localparam int VLW    = $clog2(MAX_VL) + 1,
  localparam int IDXW   = $clog2(MAX_VL)
) (
  input  logic            clk,
  input  logic            nrst,

  input  logic            start,
  input  logic [3:0]      op,
  input  logic [31:0]     base,
  input  logic [31:0]     stride,
  input  logic [VLW-1:0]  vl,

  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            err,

  v_lsu_seq_if.master     mem,

  output logic [IDXW-1:0] elem_idx,
  input  logic [31:0]     vrf_rdata,
  output logic            vrf_we,
  output logic [IDXW-1:0] vrf_widx,
  output logic [31:0]     vrf_wdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    EW8,
    EW16,
    EW32
  } ew_t;

  typedef struct packed {
    logic valid;
    logic store;
    logic strided;
    ew_t  ew;
  } op_dec_t;

  // Each op group of three runs 8/16/32 bits, so the width follows
  // directly from the op code.
  function automatic op_dec_t decode(input logic [3:0] o);
    op_dec_t d;
    d.valid   = (o >= 4'd1) && (o <= 4'd12);
    d.store   = (o >= 4'd7) && (o <= 4'd12);
    d.strided = (o inside {[4'd4:4'd6], [4'd10:4'd12]});
    case (o)
      4'd2, 4'd5, 4'd8, 4'd11: d.ew = EW16;
      4'd3, 4'd6, 4'd9, 4'd12: d.ew = EW32;
      default:                 d.ew = EW8;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input ew_t ew, input logic [1:0] a);
    return ((ew == EW16) && a[0]) || ((ew == EW32) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] ew_bytes(input ew_t ew);
    case (ew)
      EW16:    return 32'd2;
      EW32:    return 32'd4;
      default: return 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] ew_mask(input ew_t ew);
    case (ew)
      EW16:    return 32'h0000_FFFF;
      EW32:    return 32'hFFFF_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input ew_t ew, input logic [1:0] a);
    case (ew)
      EW16:    return 4'b0011 << a;
      EW32:    return 4'b1111;
      default: return 4'b0001 << a;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // State and captured command
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            store_q;
  logic            strided_q;
  ew_t             ew_q;
  logic [31:0]     stride_q;
  logic [VLW-1:0]  vl_q;
  logic [31:0]     addr_q;
  logic [IDXW-1:0] idx_q;
  logic            err_q, err_d;

  logic            accept;
  logic            advance;
  op_dec_t         dec_in;
  logic [4:0]      shamt;
  logic [31:0]     next_addr;
  logic            last;

  assign dec_in    = decode(op);
  assign shamt     = {addr_q[1:0], 3'b000};
  assign next_addr = addr_q + (strided_q ? stride_q : ew_bytes(ew_q));
  assign last      = ({1'b0, idx_q} == (vl_q - VLW'(1)));

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  // NOTE: every output and next-state variable gets a default before the
  // case statement, so no path through this block leaves a value unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.be    = '0;
    mem.wdata = '0;
    vrf_we    = 1'b0;
    vrf_widx  = '0;
    vrf_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!dec_in.valid) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (vl == '0) begin
            state_d = S_DONE;
          end else if (misaligned(dec_in.ew, base[1:0])) begin
            // A misaligned first element never reaches the bus.
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        mem.req   = 1'b1;
        mem.we    = store_q;
        mem.addr  = {addr_q[31:2], 2'b00};
        mem.be    = lane_be(ew_q, addr_q[1:0]);
        mem.wdata = store_q ? (vrf_rdata << shamt) : 32'h0;
        if (mem.gnt) begin
          if (store_q) advance = 1'b1;
          else         state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem.rvalid) begin
          vrf_we    = 1'b1;
          vrf_widx  = idx_q;
          vrf_wdata = (mem.rdata >> shamt) & ew_mask(ew_q);
          advance   = 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Element finished: stop after the last one. Before the next element's
    // request goes out, check its alignment. Elements already written stay
    // written.
    if (advance) begin
      if (last) begin
        state_d = S_DONE;
      end else if (misaligned(ew_q, next_addr[1:0])) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments, so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      store_q   <= 1'b0;
      strided_q <= 1'b0;
      ew_q      <= EW8;
      stride_q  <= '0;
      vl_q      <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        store_q   <= dec_in.store;
        strided_q <= dec_in.strided;
        ew_q      <= dec_in.ew;
        stride_q  <= stride;
        vl_q      <= vl;
        addr_q    <= base;
        idx_q     <= '0;
      end else if (advance) begin
        addr_q <= next_addr;           // wraps modulo 2^32
        idx_q  <= idx_q + IDXW'(1);
      end
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = !ready;
  assign done     = (state_q == S_DONE);
  // err_q is set only on the transition into DONE, so it lines up with done.
  assign err      = done && err_q;
  assign elem_idx = idx_q;

endmodule

// File: tb/tb_v_lsu_seq.sv
// ---------------------------------------------------------------------------
// tb_v_lsu_seq -- directed self-checking bench for v_lsu_seq.
// A simple memory responder grants after a programmable stall. Load data is
// answered one cycle after the grant. A negedge monitor logs bus requests,
// VRF writes and done/err pulses. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_v_lsu_seq;
  logic        clk;
  logic        nrst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] base;
  logic [31:0] stride;
  logic [5:0]  vl;
  logic        ready, busy, done, err;
  logic [4:0]  elem_idx;
  logic [31:0] vrf_rdata;
  logic        vrf_we;
  logic [4:0]  vrf_widx;
  logic [31:0] vrf_wdata;

  v_lsu_seq_if mem ();

  v_lsu_seq #(.MAX_VL(32)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .op        (op),
    .base      (base),
    .stride    (stride),
    .vl        (vl),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem       (mem),
    .elem_idx  (elem_idx),
    .vrf_rdata (vrf_rdata),
    .vrf_we    (vrf_we),
    .vrf_widx  (vrf_widx),
    .vrf_wdata (vrf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRF element i reads as {16'h0, B0|i, A0|i}
  assign vrf_rdata = {16'h0, 8'hB0 | {3'b000, elem_idx}, 8'hA0 | {3'b000, elem_idx}};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (negedge) ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          stall;
    bit          chg;
  } req_rec_t;

  req_rec_t    req_log [64];
  logic [4:0]  vw_idx  [64];
  logic [31:0] vw_data [64];
  int n_req = 0, n_vrf = 0, n_done = 0, n_lone_err = 0;
  int cyc = 0, done_cyc = 0;
  logic last_err = 1'b0;
  bit          req_open = 1'b0;
  int          cur_stall = 0;
  bit          cur_chg = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;
  logic [4:0]  s_idx;

  always @(negedge clk) begin
    cyc++;
    if (mem.req) begin
      if (!req_open) begin
        req_open = 1'b1; cur_stall = 0; cur_chg = 1'b0;
        s_addr = mem.addr; s_be = mem.be; s_wdata = mem.wdata; s_we = mem.we; s_idx = elem_idx;
      end else if (mem.addr !== s_addr || mem.be !== s_be || mem.wdata !== s_wdata ||
                   mem.we !== s_we || elem_idx !== s_idx) begin
        cur_chg = 1'b1;
      end
      if (mem.gnt) begin
        if (n_req < 64) req_log[n_req] = '{mem.addr, mem.be, mem.wdata, mem.we, cur_stall, cur_chg};
        n_req++;
        req_open = 1'b0;
      end else begin
        cur_stall++;
      end
    end
    if (vrf_we) begin
      if (n_vrf < 64) begin vw_idx[n_vrf] = vrf_widx; vw_data[n_vrf] = vrf_wdata; end
      n_vrf++;
    end
    if (done) begin n_done++; done_cyc = cyc; last_err = err; end
    if (err && !done) n_lone_err++;
  end

  // ---------------- memory responder (driven from main thread) ----------------
  bit          auto_mem = 1'b1;
  int          gnt_stall = 0;
  int          stall_cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return 32'hA0B0_C0D0 ^ a;
  endfunction

  task automatic respond();
    if (!auto_mem) return;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    if (pend) begin
      mem.rvalid = 1'b1; mem.rdata = rd_word(pend_addr); pend = 1'b0;
    end else if (mem.req) begin
      if (stall_cnt < gnt_stall) stall_cnt++;
      else begin
        mem.gnt = 1'b1; stall_cnt = 0;
        if (!mem.we) begin pend = 1'b1; pend_addr = mem.addr; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    respond();
  endtask

  int r0, v0, d0, c0;

  task automatic issue(input logic [3:0] o, input logic [31:0] b, input logic [31:0] s, input logic [5:0] n);
    r0 = n_req; v0 = n_vrf; d0 = n_done;
    start = 1'b1; op = o; base = b; stride = s; vl = n;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (n_done == d0 && k < limit) begin tick(); k++; end
    check({tag, "_done_cnt"}, n_done - d0, 1);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; op = '0; base = '0; stride = '0; vl = '0;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;

    // ---- reset state ----
    #3;
    check("rst_ready",  ready, 1);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_err",    err, 0);
    check("rst_req",    mem.req, 0);
    check("rst_we",     mem.we, 0);
    check("rst_addr",   mem.addr, 0);
    check("rst_be",     mem.be, 0);
    check("rst_wdata",  mem.wdata, 0);
    check("rst_vrf_we", vrf_we, 0);
    check("rst_widx",   vrf_widx, 0);
    check("rst_vwdata", vrf_wdata, 0);
    check("rst_idx",    elem_idx, 0);
    #9 nrst = 1'b1;
    tick();
    check("post_rst_ready", ready, 1);

    // ---- VLE32 base 0x100 vl 4 ----
    issue(4'd3, 32'h100, 32'h0, 6'd4);
    check("vle32_req_next", mem.req, 1);
    check("vle32_busy", busy, 1);
    wait_done("vle32", 100);
    check("vle32_nreq", n_req - r0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("vle32_addr%0d", i), req_log[r0+i].addr, 32'h100 + 32'(4*i));
      check($sformatf("vle32_be%0d", i),   req_log[r0+i].be, 4'hF);
      check($sformatf("vle32_we%0d", i),   req_log[r0+i].we, 0);
    end
    check("vle32_nvrf", n_vrf - v0, 4);
    check("vle32_widx0", vw_idx[v0+0], 0);
    check("vle32_widx3", vw_idx[v0+3], 3);
    check("vle32_wd0", vw_data[v0+0], 32'hA0B0C1D0);
    check("vle32_wd1", vw_data[v0+1], 32'hA0B0C1D4);
    check("vle32_wd2", vw_data[v0+2], 32'hA0B0C1D8);
    check("vle32_wd3", vw_data[v0+3], 32'hA0B0C1DC);
    check("vle32_err", last_err, 0);
    check("vle32_lat", done_cyc - c0, 9);
    check("vle32_ready_after", ready, 1);

    // ---- VSSE8 base 0x203 stride -1 vl 3 ----
    issue(4'd10, 32'h203, 32'hFFFF_FFFF, 6'd3);
    wait_done("vsse8", 100);
    check("vsse8_nreq", n_req - r0, 3);
    check("vsse8_addr0", req_log[r0+0].addr, 32'h200);
    check("vsse8_addr2", req_log[r0+2].addr, 32'h200);
    check("vsse8_be0", req_log[r0+0].be, 4'b1000);
    check("vsse8_be1", req_log[r0+1].be, 4'b0100);
    check("vsse8_be2", req_log[r0+2].be, 4'b0010);
    check("vsse8_wd0", req_log[r0+0].wdata, 32'hA000_0000);
    check("vsse8_wd1", req_log[r0+1].wdata, 32'hB1A1_0000);
    check("vsse8_wd2", req_log[r0+2].wdata, 32'h00B2_A200);
    check("vsse8_we", req_log[r0+1].we, 1);
    check("vsse8_nvrf", n_vrf - v0, 0);
    check("vsse8_lat", done_cyc - c0, 4);
    check("vsse8_err", last_err, 0);

    // ---- VSE16 base 0x40 vl 2, grant stalled 5 cycles; start held while busy ----
    gnt_stall = 5;
    issue(4'd8, 32'h40, 32'h0, 6'd2);
    start = 1'b1; op = 4'd1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_done("vse16", 100);
    gnt_stall = 0;
    check("vse16_nreq", n_req - r0, 2);
    check("vse16_stall0", req_log[r0+0].stall, 5);
    check("vse16_chg0", req_log[r0+0].chg, 0);
    check("vse16_stall1", req_log[r0+1].stall, 5);
    check("vse16_chg1", req_log[r0+1].chg, 0);
    check("vse16_addr1", req_log[r0+1].addr, 32'h40);
    check("vse16_be0", req_log[r0+0].be, 4'b0011);
    check("vse16_be1", req_log[r0+1].be, 4'b1100);
    check("vse16_wd0", req_log[r0+0].wdata, 32'h0000_B0A0);
    check("vse16_wd1", req_log[r0+1].wdata, 32'hB1A1_0000);
    check("vse16_err", last_err, 0);
    tick();
    check("vse16_no_restart", n_req - r0, 2);
    check("vse16_idle", ready, 1);

    // ---- VLSE32 base 0 stride 6 vl 3: element 1 misaligned ----
    issue(4'd6, 32'h0, 32'd6, 6'd3);
    wait_done("vlse32", 100);
    check("vlse32_nreq", n_req - r0, 1);
    check("vlse32_addr0", req_log[r0].addr, 32'h0);
    check("vlse32_nvrf", n_vrf - v0, 1);
    check("vlse32_widx", vw_idx[v0], 0);
    check("vlse32_wd", vw_data[v0], 32'hA0B0C0D0);
    check("vlse32_err", last_err, 1);
    check("vlse32_lat", done_cyc - c0, 3);

    // ---- invalid op 13 ----
    issue(4'd13, 32'h100, 32'h0, 6'd4);
    check("op13_req", mem.req, 0);
    wait_done("op13", 20);
    check("op13_nreq", n_req - r0, 0);
    check("op13_err", last_err, 1);
    check("op13_lat", done_cyc - c0, 1);

    // ---- vl = 0 ----
    issue(4'd1, 32'h100, 32'h0, 6'd0);
    wait_done("vl0", 20);
    check("vl0_nreq", n_req - r0, 0);
    check("vl0_err", last_err, 0);
    check("vl0_lat", done_cyc - c0, 1);

    // ---- misaligned first element (VLE16 at 0x1) ----
    issue(4'd2, 32'h1, 32'h0, 6'd2);
    wait_done("mis16", 20);
    check("mis16_nreq", n_req - r0, 0);
    check("mis16_err", last_err, 1);
    check("lone_err", n_lone_err, 0);

    // ---- reset while in WAIT, then stray rvalid ----
    auto_mem = 1'b0;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    issue(4'd3, 32'h300, 32'h0, 6'd2);
    mem.gnt = 1'b1;
    @(posedge clk); #1;
    mem.gnt = 1'b0;
    check("wait_busy", busy, 1);
    check("wait_req_low", mem.req, 0);
    v0 = n_vrf;
    nrst = 1'b0;
    #2;
    check("midrst_ready", ready, 1);
    check("midrst_idx", elem_idx, 0);
    nrst = 1'b1;
    mem.rvalid = 1'b1; mem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_vrf_we", vrf_we, 0);
    check("stray_ready", ready, 1);
    @(posedge clk); #1;
    mem.rvalid = 1'b0; mem.rdata = '0;
    check("stray_nvrf", n_vrf - v0, 0);
    check("stray_still_idle", ready, 1);

    // ---- next command after reset: VLE8 base 0x101 vl 2 ----
    auto_mem = 1'b1; pend = 1'b0; stall_cnt = 0;
    issue(4'd1, 32'h101, 32'h0, 6'd2);
    wait_done("vle8", 100);
    check("vle8_nreq", n_req - r0, 2);
    check("vle8_addr0", req_log[r0+0].addr, 32'h100);
    check("vle8_be0", req_log[r0+0].be, 4'b0010);
    check("vle8_be1", req_log[r0+1].be, 4'b0100);
    check("vle8_nvrf", n_vrf - v0, 2);
    check("vle8_widx1", vw_idx[v0+1], 1);
    check("vle8_wd0", vw_data[v0+0], 32'h0000_00C1);
    check("vle8_wd1", vw_data[v0+1], 32'h0000_00B0);
    check("vle8_err", last_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
